// File: rtl/collision_event_unit.sv
// Per-frame collision arbitration: player/target hit events queued through a small FIFO,
// first-contact bouncer reversal pulses, and a registered player/hazard overlap flag.
module collision_event_unit #(
    parameter int NUM_TARGETS     = 8,
    parameter int NUM_BOUNCERS    = 6,
    parameter int FIFO_DEPTH      = 4,
    parameter int COOLDOWN_FRAMES = 2,
    parameter bit MODE_MULTI      = 1'b1,
    localparam int IDX_W = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    startOfFrame,
    input  logic                    drawing_request_Player,
    input  logic [NUM_TARGETS-1:0]  drawing_request_Targets,
    input  logic [NUM_BOUNCERS-1:0] drawing_request_Bouncers,
    input  logic                    drawing_request_Walls,
    input  logic                    drawing_request_Hazard,
    output logic                    hazardCollision,
    output logic [NUM_BOUNCERS-1:0] bouncerToggle,
    output logic                    evt_valid,
    output logic [IDX_W-1:0]        evt_index,
    input  logic                    evt_ready,
    output logic [NUM_TARGETS-1:0]  frameHitMask,
    output logic [15:0]             hitTotal,
    output logic                    eventDropped
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int CD_W  = (COOLDOWN_FRAMES > 0) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_FRAMES);

    function automatic logic [NUM_TARGETS-1:0] lowest_one(input logic [NUM_TARGETS-1:0] v);
        return v & (~v + NUM_TARGETS'(1));
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_TARGETS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_TARGETS; i++)
            if (oh[i]) idx = idx | IDX_W'(i);
        return idx;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [NUM_TARGETS-1:0]  raw_hit, eligible, cand, accept, push_oh, pend_clr;
    logic [NUM_TARGETS-1:0]  frame_flag, pending;
    logic                    global_flag;
    logic [CD_W-1:0]         cooldown [NUM_TARGETS];
    logic [IDX_W-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [CNT_W-1:0]        fifo_cnt;
    logic                    fifo_full, pop, push;
    logic [NUM_BOUNCERS-1:0] bounce_hit, bounce_done;

    always_comb begin
        raw_hit = {NUM_TARGETS{drawing_request_Player}} & drawing_request_Targets;
        for (int i = 0; i < NUM_TARGETS; i++)
            eligible[i] = !frame_flag[i] && (cooldown[i] == '0) && (MODE_MULTI || !global_flag);
        cand      = startOfFrame ? '0 : (raw_hit & eligible);
        accept    = MODE_MULTI ? cand : lowest_one(cand);
        push_oh   = lowest_one(pending);
        fifo_full = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        pop       = evt_valid && evt_ready;
        push      = (|pending) && !startOfFrame && (!fifo_full || pop);
        pend_clr  = push ? push_oh : '0;
        bounce_hit = drawing_request_Bouncers & {NUM_BOUNCERS{drawing_request_Walls}};
    end

    assign evt_valid = (fifo_cnt != '0);
    // Index forced to 0 when empty so the output is clean while reset holds the FIFO empty.
    assign evt_index = evt_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending      <= '0;
            frame_flag   <= '0;
            global_flag  <= 1'b0;
            frameHitMask <= '0;
            eventDropped <= 1'b0;
            for (int i = 0; i < NUM_TARGETS; i++) cooldown[i] <= '0;
        end else if (startOfFrame) begin
            frameHitMask <= frame_flag;
            frame_flag   <= '0;
            global_flag  <= 1'b0;
            pending      <= '0;
            eventDropped <= eventDropped | (|pending);
            for (int i = 0; i < NUM_TARGETS; i++)
                if (cooldown[i] != '0) cooldown[i] <= cooldown[i] - CD_W'(1);
        end else begin
            pending     <= (pending & ~pend_clr) | accept;
            frame_flag  <= frame_flag | accept;
            global_flag <= global_flag | (|accept);
            for (int i = 0; i < NUM_TARGETS; i++)
                if (accept[i]) cooldown[i] <= CD_LOAD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            hitTotal <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                hitTotal <= sat_inc(hitTotal);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= onehot_to_idx(push_oh);
    end

    // The startOfFrame cycle counts as the first cycle of the new frame for bouncers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bounce_done     <= '0;
            bouncerToggle   <= '0;
            hazardCollision <= 1'b0;
        end else begin
            bouncerToggle   <= bounce_hit & ({NUM_BOUNCERS{startOfFrame}} | ~bounce_done);
            bounce_done     <= startOfFrame ? bounce_hit : (bounce_done | bounce_hit);
            hazardCollision <= drawing_request_Player && drawing_request_Hazard;
        end
    end

endmodule
